// File: rtl/axi_lite_master_bridge.sv
// AXI4 initiator: turns one local read/write request into a single or INCR-burst AXI transaction.
// Optional watchdog (sticky err_timeout output) is built when AXI_MST_TIMEOUT_EN is defined.
module axi_lite_master_bridge #(
  parameter logic [7:0] MST_ID = 8'd0,
  parameter int         ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [3:0]        req_len,
  input  logic [31:0]       wr_data,
  input  logic [3:0]        wr_strb,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [31:0]       rd_data,
  output logic              rd_valid,
  output logic              rd_last,
  input  logic              rd_ready,
  output logic              done,
  output logic [1:0]        done_resp,
  output logic [7:0]        ARID_M,
  output logic [ADDR_W-1:0] ARADDR_M,
  output logic [3:0]        ARLEN_M,
  output logic [2:0]        ARSIZE_M,
  output logic [1:0]        ARBURST_M,
  output logic              ARVALID_M,
  input  logic              ARREADY_M,
  input  logic [7:0]        RID_M,
  input  logic [31:0]       RDATA_M,
  input  logic [1:0]        RRESP_M,
  input  logic              RLAST_M,
  input  logic              RVALID_M,
  output logic              RREADY_M,
  output logic [7:0]        AWID_M,
  output logic [ADDR_W-1:0] AWADDR_M,
  output logic [3:0]        AWLEN_M,
  output logic [2:0]        AWSIZE_M,
  output logic [1:0]        AWBURST_M,
  output logic              AWVALID_M,
  input  logic              AWREADY_M,
  output logic [31:0]       WDATA_M,
  output logic [3:0]        WSTRB_M,
  output logic              WLAST_M,
  output logic              WVALID_M,
  input  logic              WREADY_M,
  input  logic [7:0]        BID_M,
  input  logic [1:0]        BRESP_M,
  input  logic              BVALID_M,
  output logic              BREADY_M
`ifdef AXI_MST_TIMEOUT_EN
  ,
  output logic              err_timeout
`endif
);

  typedef enum logic [2:0] {
    IDLE, RADDR, RDATA, WADDR, WDATA, WRESP, DONE
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        len_q;
  logic [3:0]        beat_cnt;
  logic              err_q;
  logic              r_hs, w_hs, last_beat, r_mism;
  logic [1:0]        resp_max;

  // Single outstanding transaction, so returned IDs carry no information.
  logic unused_ids;
  assign unused_ids = ^{RID_M, BID_M};

  assign ARID_M    = MST_ID;
  assign AWID_M    = MST_ID;
  assign ARSIZE_M  = 3'b010;
  assign AWSIZE_M  = 3'b010;
  assign ARBURST_M = 2'b01;
  assign AWBURST_M = 2'b01;
  assign ARADDR_M  = addr_q;
  assign AWADDR_M  = addr_q;
  assign ARLEN_M   = len_q;
  assign AWLEN_M   = len_q;
  assign rd_data   = RDATA_M;
  assign WDATA_M   = wr_data;
  assign WSTRB_M   = wr_strb;

  assign last_beat = (beat_cnt == len_q);
  assign r_hs      = (state == RDATA) && RVALID_M && rd_ready;
  assign w_hs      = (state == WDATA) && wr_valid && WREADY_M;
  // Slave burst length disagrees with the requested length on this beat.
  assign r_mism    = (RLAST_M != last_beat);
  assign resp_max  = (RRESP_M > done_resp) ? RRESP_M : done_resp;

  always_comb begin
    state_n   = state;
    req_ready = 1'b0;
    ARVALID_M = 1'b0;
    AWVALID_M = 1'b0;
    RREADY_M  = 1'b0;
    rd_valid  = 1'b0;
    rd_last   = 1'b0;
    WVALID_M  = 1'b0;
    wr_ready  = 1'b0;
    WLAST_M   = 1'b0;
    BREADY_M  = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_n = req_write ? WADDR : RADDR;
      end
      RADDR: begin
        ARVALID_M = 1'b1;
        if (ARREADY_M) state_n = RDATA;
      end
      RDATA: begin
        rd_valid = RVALID_M;
        rd_last  = RLAST_M;
        RREADY_M = rd_ready;
        if (r_hs && RLAST_M) state_n = DONE;
      end
      WADDR: begin
        AWVALID_M = 1'b1;
        if (AWREADY_M) state_n = WDATA;
      end
      WDATA: begin
        WVALID_M = wr_valid;
        wr_ready = WREADY_M;
        WLAST_M  = last_beat;
        if (w_hs && last_beat) state_n = WRESP;
      end
      WRESP: begin
        BREADY_M = 1'b1;
        if (BVALID_M) state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      beat_cnt  <= '0;
      err_q     <= 1'b0;
      done_resp <= 2'b00;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q    <= req_addr;
            len_q     <= req_len;
            beat_cnt  <= '0;
            err_q     <= 1'b0;
            done_resp <= 2'b00;
          end
        end
        RDATA: begin
          if (r_hs) begin
            beat_cnt <= beat_cnt + 4'd1;
            if (RLAST_M) begin
              done_resp <= (err_q || r_mism) ? 2'b10 : resp_max;
            end else begin
              done_resp <= resp_max;
              err_q     <= err_q | r_mism;
            end
          end
        end
        WDATA: begin
          if (w_hs && !last_beat) beat_cnt <= beat_cnt + 4'd1;
        end
        WRESP: begin
          if (BVALID_M) done_resp <= BRESP_M;
        end
        default: ;
      endcase
    end
  end

`ifdef AXI_MST_TIMEOUT_EN
  logic [15:0] wd_cnt;
  logic        busy;
  assign busy = (state != IDLE) && (state != DONE);

  // Watchdog only flags a stuck phase; the transaction itself keeps waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (state_n != state) wd_cnt <= '0;
      else if (busy && wd_cnt != 16'hFFFF) wd_cnt <= wd_cnt + 16'd1;
      if (wd_cnt == 16'hFFFF) err_timeout <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Bench for axi_lite_master_bridge: directed AXI slave stimulus, expected beats/responses queued
// at issue time and popped by a negedge monitor whenever the DUT presents a handshake.
module tb_axi_lite_master_bridge;
  localparam int         AW = 32;
  localparam logic [7:0] ID = 8'h5A;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [3:0]    req_len;
  logic [31:0]   wr_data;
  logic [3:0]    wr_strb;
  logic          wr_valid, wr_ready;
  logic [31:0]   rd_data;
  logic          rd_valid, rd_last, rd_ready;
  logic          done;
  logic [1:0]    done_resp;
  logic [7:0]    ARID_M, AWID_M, RID_M, BID_M;
  logic [AW-1:0] ARADDR_M, AWADDR_M;
  logic [3:0]    ARLEN_M, AWLEN_M, WSTRB_M;
  logic [2:0]    ARSIZE_M, AWSIZE_M;
  logic [1:0]    ARBURST_M, AWBURST_M, RRESP_M, BRESP_M;
  logic          ARVALID_M, ARREADY_M, RLAST_M, RVALID_M, RREADY_M;
  logic          AWVALID_M, AWREADY_M, WLAST_M, WVALID_M, WREADY_M;
  logic [31:0]   RDATA_M, WDATA_M;
  logic          BVALID_M, BREADY_M;
`ifdef AXI_MST_TIMEOUT_EN
  logic          err_timeout;
`endif

  always #5 clk = ~clk;

  axi_lite_master_bridge #(.MST_ID(ID), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
    .done(done), .done_resp(done_resp),
    .ARID_M(ARID_M), .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M), .ARSIZE_M(ARSIZE_M),
    .ARBURST_M(ARBURST_M), .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
    .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RLAST_M(RLAST_M),
    .RVALID_M(RVALID_M), .RREADY_M(RREADY_M),
    .AWID_M(AWID_M), .AWADDR_M(AWADDR_M), .AWLEN_M(AWLEN_M), .AWSIZE_M(AWSIZE_M),
    .AWBURST_M(AWBURST_M), .AWVALID_M(AWVALID_M), .AWREADY_M(AWREADY_M),
    .WDATA_M(WDATA_M), .WSTRB_M(WSTRB_M), .WLAST_M(WLAST_M), .WVALID_M(WVALID_M),
    .WREADY_M(WREADY_M),
    .BID_M(BID_M), .BRESP_M(BRESP_M), .BVALID_M(BVALID_M), .BREADY_M(BREADY_M)
`ifdef AXI_MST_TIMEOUT_EN
    , .err_timeout(err_timeout)
`endif
  );

  typedef struct packed { logic [31:0] addr; logic [3:0] len; } a_t;

  a_t          exp_ar[$], exp_aw[$];
  logic [32:0] exp_rd[$];   // {last, data}
  logic [36:0] exp_w[$];    // {last, strb, data}
  logic [1:0]  exp_done[$];
  int          tests = 0, fails = 0;
  logic [31:0] rdat[16];
  logic        rlst[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    tests++;
    fails++;
    $display("FAIL %s: handshake with no expected entry queued", name);
  endtask

  // Monitor: compares every DUT-side handshake against the scoreboard queues.
  logic        prev_done = 1'b0;
  a_t          m_a;
  logic [32:0] m_r;
  logic [36:0] m_w;
  always @(negedge clk) begin
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      if (ARVALID_M && ARREADY_M) begin
        if (exp_ar.size() == 0) unexpected("ar");
        else begin
          m_a = exp_ar.pop_front();
          check("araddr", ARADDR_M, m_a.addr);
          check("arlen", ARLEN_M, m_a.len);
          check("ar_fixed", {ARID_M, ARSIZE_M, ARBURST_M}, {ID, 3'b010, 2'b01});
        end
      end
      if (AWVALID_M && AWREADY_M) begin
        if (exp_aw.size() == 0) unexpected("aw");
        else begin
          m_a = exp_aw.pop_front();
          check("awaddr", AWADDR_M, m_a.addr);
          check("awlen", AWLEN_M, m_a.len);
          check("aw_fixed", {AWID_M, AWSIZE_M, AWBURST_M}, {ID, 3'b010, 2'b01});
        end
      end
      if (rd_valid && rd_ready) begin
        if (exp_rd.size() == 0) unexpected("rd");
        else begin
          m_r = exp_rd.pop_front();
          check("rd_beat", {rd_last, rd_data}, m_r);
        end
      end
      if (WVALID_M && WREADY_M) begin
        if (exp_w.size() == 0) unexpected("w");
        else begin
          m_w = exp_w.pop_front();
          check("w_beat", {WLAST_M, WSTRB_M, WDATA_M}, m_w);
        end
      end
      if (done) begin
        check("done_pulse_width", prev_done, 0);
        if (exp_done.size() == 0) unexpected("done");
        else check("done_resp", done_resp, exp_done.pop_front());
      end
      prev_done = done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [31:0] a, input logic [3:0] l);
    int n = 0;
    while (!req_ready && n < 20) begin tick(); n++; end
    check("req_ready_before_issue", req_ready, 1);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_len = l;
    if (wr) exp_aw.push_back('{addr: a, len: l});
    else    exp_ar.push_back('{addr: a, len: l});
    tick();
    req_valid = 1'b0;
    check("req_ready_busy", req_ready, 0);
  endtask

  task automatic ar_phase();
    int n = 0;
    while (!ARVALID_M && n < 20) begin tick(); n++; end
    check("arvalid_wait", ARVALID_M, 1);
    ARREADY_M = 1'b1;
    tick();
    ARREADY_M = 1'b0;
  endtask

  task automatic aw_phase();
    int n = 0;
    while (!AWVALID_M && n < 20) begin tick(); n++; end
    check("awvalid_wait", AWVALID_M, 1);
    check("no_w_before_aw", wr_ready, 0);
    AWREADY_M = 1'b1;
    tick();
    AWREADY_M = 1'b0;
  endtask

  task automatic r_beats(input int n, input bit toggle);
    int cyc = 0;
    int guard;
    bit hs;
    for (int i = 0; i < n; i++) begin
      hs = 1'b0; guard = 0;
      RVALID_M = 1'b1; RDATA_M = rdat[i]; RLAST_M = rlst[i]; RRESP_M = 2'b00;
      while (!hs && guard < 50) begin
        rd_ready = toggle ? (cyc % 2 == 0) : 1'b1;
        cyc++;
        #1;
        check("rready_mirror", RREADY_M, rd_ready);
        hs = RREADY_M && RVALID_M;
        tick();
        guard++;
      end
      if (!hs) unexpected("r_beat_timeout");
    end
    RVALID_M = 1'b0; RLAST_M = 1'b0; rd_ready = 1'b0;
  endtask

  // Drives n_do beats of an n_total burst; stall_beat gets WREADY low for two cycles.
  task automatic w_beats(input int n_total, input int n_do, input bit gaps, input int stall_beat);
    int beat = 0, cyc = 0, stall = 0, guard = 0;
    bit hs;
    while (beat < n_do && guard < 200) begin
      wr_valid = gaps ? (cyc % 3 != 1) : 1'b1;
      wr_data  = 32'hC0DE_0000 + beat;
      wr_strb  = 4'(beat) ^ 4'hF;
      WREADY_M = 1'b1;
      if (beat == stall_beat && stall < 2) begin WREADY_M = 1'b0; stall++; end
      #1;
      check("wr_ready_mirror", wr_ready, WREADY_M);
      hs = wr_valid && wr_ready;
      if (hs) exp_w.push_back({(beat == n_total - 1), 4'(beat) ^ 4'hF, 32'hC0DE_0000 + beat});
      tick();
      if (hs) beat++;
      cyc++; guard++;
    end
    if (beat < n_do) unexpected("w_beat_timeout");
    wr_valid = 1'b0; WREADY_M = 1'b0;
  endtask

  task automatic b_phase(input logic [1:0] resp);
    int n = 0;
    BVALID_M = 1'b1; BRESP_M = resp;
    #1;
    while (!BREADY_M && n < 20) begin tick(); n++; end
    check("bready", BREADY_M, 1);
    tick();
    BVALID_M = 1'b0; BRESP_M = 2'b00;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!req_ready && n < 20) begin tick(); n++; end
    check("req_ready_after_done", req_ready, 1);
  endtask

  task automatic check_quiet(input string name);
    check(name, {ARVALID_M, AWVALID_M, WVALID_M, RREADY_M, BREADY_M, rd_valid, wr_ready, done, req_ready},
          9'b0_0000_0001);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 0; req_write = 0; req_addr = '0; req_len = '0;
    wr_data = '0; wr_strb = '0; wr_valid = 0; rd_ready = 0;
    ARREADY_M = 0; AWREADY_M = 0; WREADY_M = 0;
    RID_M = 8'h33; RDATA_M = '0; RRESP_M = '0; RLAST_M = 0; RVALID_M = 0;
    BID_M = 8'h44; BRESP_M = '0; BVALID_M = 0;
    repeat (3) tick();
    check_quiet("reset_outputs");
    check("reset_done_resp", done_resp, 0);
`ifdef AXI_MST_TIMEOUT_EN
    check("reset_err_timeout", err_timeout, 0);
`endif
    rst = 1'b0;
    tick();
    check_quiet("post_reset_idle");

    // Single-beat read
    issue(1'b0, 32'h1000_0100, 4'd0);
    rdat[0] = 32'hA5A5_0001; rlst[0] = 1'b1;
    exp_rd.push_back({1'b1, 32'hA5A5_0001});
    exp_done.push_back(2'b00);
    ar_phase();
    r_beats(1, 1'b0);
    wait_idle();
    check("done_resp_single_read", done_resp, 0);

    // 4-beat read, sink toggles ready
    issue(1'b0, 32'h2000_0040, 4'd3);
    for (int i = 0; i < 4; i++) begin
      rdat[i] = 32'h1111_0000 + i; rlst[i] = (i == 3);
      exp_rd.push_back({(i == 3), 32'h1111_0000 + i});
    end
    exp_done.push_back(2'b00);
    ar_phase();
    r_beats(4, 1'b1);
    wait_idle();

    // 8-beat write with local gaps and a 2-cycle slave stall on beat 3
    issue(1'b1, 32'h3000_0000, 4'd7);
    exp_done.push_back(2'b00);
    aw_phase();
    w_beats(8, 8, 1'b1, 2);
    b_phase(2'b00);
    wait_idle();

    // Read where the slave ends the burst early on beat 2
    issue(1'b0, 32'h4000_0010, 4'd3);
    rdat[0] = 32'hBEEF_0000; rlst[0] = 1'b0;
    rdat[1] = 32'hBEEF_0001; rlst[1] = 1'b1;
    exp_rd.push_back({1'b0, 32'hBEEF_0000});
    exp_rd.push_back({1'b1, 32'hBEEF_0001});
    exp_done.push_back(2'b10);
    ar_phase();
    r_beats(2, 1'b0);
    wait_idle();

    // Single-beat write answered with SLVERR; done_resp must hold afterwards
    issue(1'b1, 32'h5000_0004, 4'd0);
    exp_done.push_back(2'b10);
    aw_phase();
    w_beats(1, 1, 1'b0, -1);
    b_phase(2'b10);
    wait_idle();
    repeat (3) tick();
    check("done_resp_hold", done_resp, 2'b10);

    // Reset in the middle of an 8-beat write, while beat 4 is being presented
    issue(1'b1, 32'h6000_0000, 4'd7);
    aw_phase();
    w_beats(8, 4, 1'b0, -1);
    wr_valid = 1'b1; wr_data = 32'hDEAD_0004; wr_strb = 4'hF; WREADY_M = 1'b1;
    #1;
    check("wvalid_before_reset", WVALID_M, 1);
    rst = 1'b1;
    #1;
    check_quiet("reset_mid_burst");
    check("reset_mid_done_resp", done_resp, 0);
    wr_valid = 1'b0; WREADY_M = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check_quiet("after_reset_release");

    // Normal read after the abandoned write
    issue(1'b0, 32'h7000_0020, 4'd1);
    rdat[0] = 32'h0000_7777; rlst[0] = 1'b0;
    rdat[1] = 32'h0000_8888; rlst[1] = 1'b1;
    exp_rd.push_back({1'b0, 32'h0000_7777});
    exp_rd.push_back({1'b1, 32'h0000_8888});
    exp_done.push_back(2'b00);
    ar_phase();
    r_beats(2, 1'b0);
    wait_idle();

`ifdef AXI_MST_TIMEOUT_EN
    check("err_timeout_quiet", err_timeout, 0);
    issue(1'b0, 32'h8000_0000, 4'd0);
    repeat (65540) tick();
    check("err_timeout_set", err_timeout, 1);
    rdat[0] = 32'h0000_9999; rlst[0] = 1'b1;
    exp_rd.push_back({1'b1, 32'h0000_9999});
    exp_done.push_back(2'b00);
    ar_phase();
    r_beats(1, 1'b0);
    wait_idle();
    check("err_timeout_sticky", err_timeout, 1);
`endif

    repeat (3) tick();
    check("left_ar", exp_ar.size(), 0);
    check("left_aw", exp_aw.size(), 0);
    check("left_rd", exp_rd.size(), 0);
    check("left_w", exp_w.size(), 0);
    check("left_done", exp_done.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
